// File: rtl/duck_shot_judge.sv
// Shot judge for the duck game: debounces the gun trigger, tests the latched aim point
// against the latched duck box, and maintains BCD score, ammo, screen flash and respawn request.
module duck_shot_judge #(
    parameter int DUCK_W       = 46,
    parameter int DUCK_H       = 40,
    parameter int SHOTS        = 3,
    parameter int DEBOUNCE_LEN = 250000,
    parameter int FLASH_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               reload,
    input  logic               frame_tick,
    input  logic [9:0]         aim_x,
    input  logic [9:0]         aim_y,
    input  logic signed [10:0] duck_x,
    input  logic signed [9:0]  duck_y,
    output logic               hit,
    output logic               duck_kill,
    output logic               flash,
    output logic [7:0]         score,
    output logic [1:0]         ammo,
    output logic               empty
);

    localparam int DB_W = $clog2(DEBOUNCE_LEN + 1);
    localparam int FC_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [1:0]        FULL_AMMO = 2'(SHOTS);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LEN - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FLASH_FRAMES - 1);
    localparam logic signed [11:0] BOX_W    = 12'(DUCK_W);
    localparam logic signed [11:0] BOX_H    = 12'(DUCK_H);

    typedef enum logic [1:0] {READY, JUDGE, FLASH, EMPTY} state_t;

    state_t state, state_d;

    logic            sync1, sync2;
    logic            db_level, db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            fire;

    logic [9:0]         lat_ax, lat_ay;
    logic signed [10:0] lat_dx;
    logic signed [9:0]  lat_dy;
    logic [FC_W-1:0]    frame_cnt;

    logic signed [11:0] ax, ay, dx, dy;
    logic               in_box;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // The debounced level only follows the synchronized trigger after a full run of
    // disagreeing cycles; fire is registered so it is a clean single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
            fire     <= 1'b0;
        end else begin
            sync1   <= trigger;
            sync2   <= sync1;
            db_prev <= db_level;
            fire    <= db_level & ~db_prev;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Aim is unsigned screen space, duck may hang off the left/top edge, so both are
    // widened to 12-bit signed before the box compare.
    assign ax = $signed({2'b00, lat_ax});
    assign ay = $signed({2'b00, lat_ay});
    assign dx = $signed({lat_dx[10], lat_dx});
    assign dy = $signed({{2{lat_dy[9]}}, lat_dy});
    assign in_box = (ax >= dx) && (ax < dx + BOX_W) && (ay >= dy) && (ay < dy + BOX_H);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= READY;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        hit       = 1'b0;
        duck_kill = 1'b0;
        flash     = 1'b0;
        empty     = 1'b0;
        case (state)
            READY: begin
                if (fire && ammo != 2'd0)
                    state_d = JUDGE;
            end
            JUDGE: begin
                hit       = in_box;
                duck_kill = in_box;
                state_d   = FLASH;
            end
            FLASH: begin
                flash = 1'b1;
                if (frame_tick && frame_cnt == FC_LAST)
                    state_d = (ammo == 2'd0) ? EMPTY : READY;
            end
            EMPTY: begin
                empty = 1'b1;
                if (reload)
                    state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    // Shot data, score and ammo; the frame counter is cleared while judging so a tick
    // landing on the JUDGE->FLASH edge is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_ax    <= '0;
            lat_ay    <= '0;
            lat_dx    <= '0;
            lat_dy    <= '0;
            score     <= 8'h00;
            ammo      <= FULL_AMMO;
            frame_cnt <= '0;
        end else begin
            case (state)
                READY: begin
                    if (fire && ammo != 2'd0) begin
                        lat_ax <= aim_x;
                        lat_ay <= aim_y;
                        lat_dx <= duck_x;
                        lat_dy <= duck_y;
                    end
                end
                JUDGE: begin
                    frame_cnt <= '0;
                    if (in_box) begin
                        score <= bcd_inc(score);
                        ammo  <= FULL_AMMO;
                    end else begin
                        ammo <= ammo - 2'd1;
                    end
                end
                FLASH: begin
                    if (frame_tick)
                        frame_cnt <= frame_cnt + 1'b1;
                end
                EMPTY: begin
                    if (reload)
                        ammo <= FULL_AMMO;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/duck_shot_judge.md
Name: duck_shot_judge

Overview:
- Downstream consumer of the duck sprite stage. Takes the duck's signed screen position (pos_x, pos_y) and the player's aim point, debounces the trigger, and judges each shot as hit or miss.
- Maintains a BCD score and an ammo count, and drives the screen-flash and duck-respawn request used by the VGA mux and the duck stage.

Parameters:
- DUCK_W, 46, duck sprite width in pixels.
- DUCK_H, 40, duck sprite height in pixels.
- SHOTS, 3, ammo loaded at reset, on reload and after a hit (1..3).
- DEBOUNCE_LEN, 250000, cycles the synchronized trigger must stay stable before it is accepted.
- FLASH_FRAMES, 4, frame_tick count the flash stays asserted after a shot.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  1  raw gun button, asynchronous, active-high
- reload  in  1  single-cycle pulse, refills ammo when empty
- frame_tick  in  1  single-cycle pulse once per frame (start of vsync)
- aim_x  in  10  crosshair column, 0..639
- aim_y  in  10  crosshair row, 0..479
- duck_x  in  11 signed  duck left edge, driven from the duck stage's pos_x
- duck_y  in  10 signed  duck top edge, driven from the duck stage's pos_y
- hit  out  1  one-cycle pulse on a judged hit
- duck_kill  out  1  one-cycle pulse, same cycle as hit; respawn request to the duck stage
- flash  out  1  high while a shot flash is active
- score  out  8  two BCD digits, {tens, ones}, 00..99
- ammo  out  2  remaining shots
- empty  out  1  high in the EMPTY state

Behaviour:
- Reset (async, active-high) forces:
  - FSM to READY.
  - score=8'h00, ammo=SHOTS.
  - hit, duck_kill, flash, empty = 0.
  - Debounce counter and synchronizer flops cleared.
- Trigger conditioning:
  - 2-flop synchronizer on trigger.
  - Debounced level updates only after the synchronized value differs from it for DEBOUNCE_LEN consecutive cycles; any mismatch-free cycle restarts the count.
  - fire = one-cycle pulse on the debounced rising edge.
- FSM states: READY, JUDGE, FLASH, EMPTY.
- READY:
  - fire with ammo>0 -> latch aim_x, aim_y, duck_x, duck_y into registers -> JUDGE.
  - fire with ammo==0 does not occur, because ammo==0 is only reachable in EMPTY.
- JUDGE (exactly 1 cycle):
  - All compares use 12-bit signed arithmetic; aim values are zero-extended, duck values sign-extended.
  - In-box test: lx<=ax<lx+DUCK_W and ly<=ay<ly+DUCK_H, on the latched values.
  - Hit:
    - hit=1 and duck_kill=1 for this one cycle.
    - score incremented in BCD (ones 9 -> 0 with tens+1), saturating at 8'h99.
    - ammo=SHOTS.
    - Next state FLASH.
  - Miss: ammo=ammo-1; next state FLASH.
  - Latency: hit/duck_kill are asserted 1 cycle after the fire pulse. Total trigger-to-hit latency is 2 sync cycles + DEBOUNCE_LEN + 2 cycles.
- FLASH:
  - flash=1 on entry; a frame counter clears on entry.
  - Each frame_tick increments the counter. A frame_tick coinciding with the JUDGE->FLASH transition cycle is not counted.
  - On the FLASH_FRAMES-th tick: flash=0; next state is EMPTY if ammo==0, else READY.
  - fire pulses while in FLASH are discarded, not queued.
- EMPTY:
  - empty=1; fire ignored.
  - reload -> ammo=SHOTS, empty=0 -> READY.
  - reload in any other state is ignored.
- Duck partially offscreen (duck_x negative, down to -46): the in-box test still applies, so aim_x=0 is a hit when duck_x=-10.
- Duck inputs change every cycle; only the values latched on the fire cycle are judged.
- A reset asserted mid-JUDGE or mid-FLASH aborts immediately. No hit pulse and no score change escape in that case.

Test Plan:
- Reset, then hold trigger high for DEBOUNCE_LEN+4 cycles with aim=(300,170), duck=(280,150) -> hit pulses once 1 cycle after fire; score=8'h01; ammo=3; flash high for 4 frame_ticks, then READY.
- Three misses: aim=(10,10), duck=(400,300) -> ammo 3->2->1->0; after the third flash, empty=1; a further trigger gives no change; reload -> ammo=3, empty=0.
- Bounce: toggle trigger every 1000 cycles for 50 toggles, then hold high -> exactly one fire and one judgement.
- Offscreen edges with duck_x=-10, duck_y=150:
  - aim=(0,150) -> hit.
  - aim=(36,150) -> miss (right edge exclusive).
  - aim=(35,189) -> hit; aim=(35,190) -> miss.
- Score wrap: force 9 hits from score 8'h09 -> 8'h10 after the first of them; starting from 8'h99, another hit -> stays 8'h99 with hit still pulsing.
- Assert reset during FLASH, and separately in the JUDGE cycle -> flash=0 and ammo=3 immediately; score=00; no hit pulse observed.
